// File: rtl/fifo_pkg.sv
// Shared sizing helpers and defaults for the FIFO pointer/flag controller.
package fifo_pkg;

  localparam int unsigned DEF_W          = 8;
  localparam int unsigned AEMPTY_DEFAULT = 2;

  function automatic int unsigned depth_of(input int unsigned w);
    return 32'd1 << w;
  endfunction

  function automatic int unsigned afull_default(input int unsigned w);
    return (32'd1 << w) - 32'd2;
  endfunction

  function automatic int unsigned count_width(input int unsigned w);
    return w + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer/count/flag controller for a dual-port buffer with a registered read port,
// presenting the head word first-word-fall-through via a lookahead read address.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_BUFFER_LENGTH_WIDTH = DEF_W,
  parameter int unsigned AFULL_THRESH             = afull_default(DATA_BUFFER_LENGTH_WIDTH),
  parameter int unsigned AEMPTY_THRESH            = AEMPTY_DEFAULT
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                wr_req,
  input  logic                                rd_req,
  input  logic                                flush,
  input  logic                                clr_err,
  output logic [DATA_BUFFER_LENGTH_WIDTH-1:0] wraddress,
  output logic [DATA_BUFFER_LENGTH_WIDTH-1:0] rdaddress,
  output logic                                wren,
  output logic                                full,
  output logic                                empty,
  output logic                                almost_full,
  output logic                                almost_empty,
  output logic [DATA_BUFFER_LENGTH_WIDTH:0]   count,
  output logic                                overflow,
  output logic                                underflow
);

  localparam int unsigned W  = DATA_BUFFER_LENGTH_WIDTH;
  localparam int unsigned CW = count_width(W);
  localparam logic [CW-1:0] DEPTH_C = CW'(depth_of(W));
  localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);

  logic [W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          stale_q, stale_d;
  logic          af_q, ae_q;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          wr_fire, rd_fire;

  assign full    = (count_q == DEPTH_C);
  // A word written to the address being read this edge is not visible on q until
  // one cycle later, so it is hidden behind empty for that cycle.
  assign empty   = (count_q == '0) | stale_q;
  assign wr_fire = wr_req & ~full & ~flush & ~reset;
  assign rd_fire = rd_req & ~empty;

  assign wren      = wr_fire;
  assign wraddress = wr_ptr_q;
  assign rdaddress = rd_fire ? rd_ptr_q + W'(1) : rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (wr_fire ? W'(1) : W'(0));
    rd_ptr_d = rd_ptr_q + (rd_fire ? W'(1) : W'(0));
    count_d  = count_q;
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    stale_d = wr_fire & (wr_ptr_q == rdaddress);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      stale_d  = 1'b0;
    end
    // A fresh error in the clearing cycle keeps the flag set.
    ovf_d = (ovf_q & ~clr_err) | (wr_req & full);
    unf_d = (unf_q & ~clr_err) | (rd_req & empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stale_q  <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stale_q  <= stale_d;
      af_q     <= (count_d >= AF_C);
      ae_q     <= (count_d <= AE_C);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign count        = count_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl with a registered-read buffer model and a data scoreboard.
module tb_fifo_ctrl;

  localparam int W = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0, reset = 1'b1;
  logic wr_req = 0, rd_req = 0, flush = 0, clr_err = 0;
  logic [W-1:0] wraddress, rdaddress;
  logic wren, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [W:0] count;
  logic [7:0] wdata = 0, q;
  logic [7:0] mem [DEPTH];

  int n_chk = 0, n_pass = 0;
  logic [7:0] sb[$];
  int mcnt;
  logic [W-1:0] mwp, mrp;
  bit mstale, mov, mun;

  fifo_ctrl #(.DATA_BUFFER_LENGTH_WIDTH(W), .AFULL_THRESH(6), .AEMPTY_THRESH(2)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .rd_req(rd_req), .flush(flush),
    .clr_err(clr_err), .wraddress(wraddress), .rdaddress(rdaddress), .wren(wren),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // buffer: registered read, read-during-write returns old data
  always @(posedge clk) begin
    if (wren) mem[wraddress] <= wdata;
    q <= mem[rdaddress];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  task automatic mreset();
    mcnt = 0; mwp = 0; mrp = 0; mstale = 0; mov = 0; mun = 0;
    sb.delete();
  endtask

  // one clock of stimulus; checks all outputs against the model before the edge
  task automatic op(input bit w, input bit r, input logic [7:0] d,
                    input bit f = 0, input bit ce = 0);
    bit efull, eempty, wf, rf;
    logic [W-1:0] erd;
    wr_req = w; rd_req = r; wdata = d; flush = f; clr_err = ce;
    #1;
    efull  = (mcnt == DEPTH);
    eempty = (mcnt == 0) || mstale;
    wf = w & ~efull & ~f;
    rf = r & ~eempty;
    erd = rf ? mrp + 3'd1 : mrp;
    chk("count", count, mcnt);
    chk("full", full, efull);
    chk("empty", empty, eempty);
    chk("afull", almost_full, mcnt >= 6);
    chk("aempty", almost_empty, mcnt <= 2);
    chk("ovf", overflow, mov);
    chk("unf", underflow, mun);
    chk("wren", wren, wf);
    chk("wraddr", wraddress, mwp);
    chk("rdaddr", rdaddress, erd);
    if (rf) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) chk("q", q, sb.pop_front());
    end
    if (wf) sb.push_back(d);
    @(posedge clk); #1;
    mov = (mov & ~ce) | (w & efull);
    mun = (mun & ~ce) | (r & eempty);
    if (f) begin
      mwp = 0; mrp = 0; mcnt = 0; mstale = 0; sb.delete();
    end else begin
      mstale = wf && (mwp == erd);
      if (wf) mwp = mwp + 3'd1;
      if (rf) mrp = mrp + 3'd1;
      mcnt = mcnt + int'(wf) - int'(rf);
    end
    wr_req = 0; rd_req = 0; flush = 0; clr_err = 0;
  endtask

  initial begin
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_wren", wren, 0);
    reset = 0;

    // 1: reset mid-stream
    for (int i = 0; i < 3; i++) op(1, 0, 8'h10 + i[7:0]);
    chk("t1_pre_cnt", count, 3);
    #2 reset = 1;
    #1;
    chk("t1_cnt", count, 0);
    chk("t1_empty", empty, 1);
    chk("t1_aempty", almost_empty, 1);
    chk("t1_full", full, 0);
    chk("t1_ovf", overflow, 0);
    chk("t1_unf", underflow, 0);
    chk("t1_rdaddr", rdaddress, 0);
    @(posedge clk); #1;
    reset = 0;
    mreset();

    // 2: push into empty, first-word fall-through latency
    op(1, 0, 8'hA5);
    chk("t2_stale_empty", empty, 1);
    op(0, 0, 8'h00);
    chk("t2_empty", empty, 0);
    chk("t2_q", q, 8'hA5);
    op(0, 1, 8'h00);
    chk("t2_pop_empty", empty, 1);
    chk("t2_pop_cnt", count, 0);

    // 3: fill, overflow, drain across pointer wrap, underflow
    for (int i = 0; i < DEPTH; i++) begin
      op(1, 0, i[7:0]);
      chk("t3_af", almost_full, i >= 5);
    end
    chk("t3_full", full, 1);
    chk("t3_cnt", count, 8);
    op(1, 0, 8'hFF);
    chk("t3_ovf", overflow, 1);
    for (int i = 0; i < DEPTH; i++) op(0, 1, 8'h00);
    chk("t3_sb_drained", sb.size(), 0);
    op(0, 1, 8'h00);
    chk("t3_unf", underflow, 1);
    op(0, 0, 8'h00, 0, 1);
    chk("t3_clr", {overflow, underflow}, 2'b00);

    // 4: simultaneous rd/wr at count==1
    op(1, 0, 8'h11);
    op(0, 0, 8'h00);
    op(1, 1, 8'h22);
    chk("t4_cnt", count, 1);
    chk("t4_empty_pulse", empty, 1);
    op(0, 0, 8'h00);
    chk("t4_empty_back", empty, 0);
    chk("t4_q", q, 8'h22);
    op(0, 1, 8'h00);

    // 5: simultaneous rd/wr while full
    op(0, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) op(1, 0, 8'h30 + i[7:0]);
    chk("t5_q_head", q, 8'h30);
    op(1, 1, 8'hEE);
    chk("t5_cnt", count, 7);
    chk("t5_ovf", overflow, 1);
    for (int i = 0; i < 7; i++) op(0, 1, 8'h00);
    chk("t5_cnt0", count, 0);

    // 6: flush with wr_req pending, errors preserved, then cleared
    op(0, 1, 8'h00);
    for (int i = 0; i < 5; i++) op(1, 0, 8'h50 + i[7:0]);
    op(1, 0, 8'h77, 1, 0);
    chk("t6_cnt", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_errs", {overflow, underflow}, 2'b11);
    op(0, 1, 8'h00, 0, 1);
    chk("t6_clr_newerr", {overflow, underflow}, 2'b01);
    op(0, 0, 8'h00, 0, 1);
    chk("t6_clr", {overflow, underflow}, 2'b00);
    op(1, 0, 8'h99);
    op(0, 0, 8'h00);
    op(0, 1, 8'h00);
    chk("t6_after_flush_cnt", count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
